// File: rtl/fft_pkg.sv
// Shared FFT definitions: size helpers, bit-reverse, reorder read-FSM states.
// Used by the SDF stages, the twiddle ROM and the output reorder buffer.
package fft_pkg;

  localparam int MAX_LOGN = 16;
  localparam int IDX_W    = $clog2(MAX_LOGN);

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_t;

  function automatic int fft_n(input int lg);
    return 1 << lg;
  endfunction

  function automatic int fft_hn(input int lg);
    return 1 << (lg - 1);
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_LOGN-1:0] bitrev(input logic [MAX_LOGN-1:0] v, input int w);
    logic [MAX_LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOGN; i++) begin
      if (i < w) r[IDX_W'(i)] = v[IDX_W'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream into and out of the bit-reverse reorder buffer.
// master = upstream/consumer side, slave = the reorder buffer itself.
interface fft_bitrev_reorder_if #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
);

  logic                       in_valid;
  logic [FLOAT_PRECISION-1:0] di_re;
  logic [FLOAT_PRECISION-1:0] di_im;
  logic                       out_valid;
  logic [logn-1:0]            out_idx;
  logic [FLOAT_PRECISION-1:0] do_re;
  logic [FLOAT_PRECISION-1:0] do_im;
  logic                       overflow;

  modport master (
    output in_valid, di_re, di_im,
    input  out_valid, out_idx, do_re, do_im, overflow
  );

  modport slave (
    input  in_valid, di_re, di_im,
    output out_valid, out_idx, do_re, do_im, overflow
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Address is {bank, index}; contents are never reset so it maps onto block RAM.
module fft_pingpong_ram #(
  parameter int WIDTH = 128,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Collects bit-reversed FFT frames into a ping-pong RAM and replays each
// frame as a gap-free natural-order burst tagged with its bin index.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
) (
  input  logic               clk,
  input  logic               rst,
  fft_bitrev_reorder_if.slave bus
);

  localparam int W  = 2 * FLOAT_PRECISION;
  localparam int AW = logn + 1;

  // Write side
  logic            wr_bank_reg;
  logic [logn-1:0] wr_cnt_reg;
  logic [1:0]      full_reg;
  logic            overflow_reg;
  logic            wr_en;
  logic            wr_drop;
  logic            wr_wrap;
  logic [AW-1:0]   wr_addr;
  logic [1:0]      full_set;
  logic [1:0]      full_clr;

  // Read side
  rd_state_t       state_reg, state_next;
  logic            rd_bank_reg, rd_bank_next;
  logic [logn-1:0] rd_cnt_reg, rd_cnt_next;
  logic            rd_issue;
  logic            rd_done;
  logic [AW-1:0]   rd_addr;
  logic [W-1:0]    rd_data;

  // Output pipeline
  logic                       valid_d1_reg;
  logic [logn-1:0]            idx_d1_reg;
  logic                       out_valid_reg;
  logic [logn-1:0]            out_idx_reg;
  logic [FLOAT_PRECISION-1:0] do_re_reg;
  logic [FLOAT_PRECISION-1:0] do_im_reg;

  assign wr_drop = bus.in_valid &&  full_reg[wr_bank_reg];
  assign wr_en   = bus.in_valid && !full_reg[wr_bank_reg];
  assign wr_wrap = wr_en && (&wr_cnt_reg);
  assign wr_addr = {wr_bank_reg, logn'(bitrev(MAX_LOGN'(wr_cnt_reg), logn))};
  assign rd_addr = {rd_bank_reg, rd_cnt_reg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign full_set[gi] = wr_wrap && (wr_bank_reg == 1'(gi));
    assign full_clr[gi] = rd_done && (rd_bank_reg == 1'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_reg  <= 1'b0;
      wr_cnt_reg   <= '0;
      full_reg     <= 2'b00;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_cnt_reg <= wr_cnt_reg + 1'b1;
      if (wr_wrap) wr_bank_reg <= ~wr_bank_reg;
      if (wr_drop) overflow_reg <= 1'b1;
      full_reg <= (full_reg & ~full_clr) | full_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= R_IDLE;
      rd_bank_reg <= 1'b0;
      rd_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      rd_bank_reg <= rd_bank_next;
      rd_cnt_reg  <= rd_cnt_next;
    end
  end

  // Full flags written this edge are only visible next cycle, so a frame
  // finishing exactly as the other bank drains costs one idle cycle.
  always_comb begin
    state_next   = state_reg;
    rd_bank_next = rd_bank_reg;
    rd_cnt_next  = rd_cnt_reg;
    rd_issue     = 1'b0;
    rd_done      = 1'b0;
    case (state_reg)
      R_IDLE: begin
        if (full_reg[rd_bank_reg]) begin
          state_next  = R_READ;
          rd_cnt_next = '0;
        end
      end
      R_READ: begin
        rd_issue    = 1'b1;
        rd_cnt_next = rd_cnt_reg + 1'b1;
        if (&rd_cnt_reg) begin
          rd_done      = 1'b1;
          rd_bank_next = ~rd_bank_reg;
          state_next   = full_reg[~rd_bank_reg] ? R_READ : R_IDLE;
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  fft_pingpong_ram #(
    .WIDTH (W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({bus.di_re, bus.di_im}),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Data registers hold while idle so the outputs never go X between bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d1_reg  <= 1'b0;
      idx_d1_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      do_re_reg     <= '0;
      do_im_reg     <= '0;
    end else begin
      valid_d1_reg  <= rd_issue;
      idx_d1_reg    <= rd_cnt_reg;
      out_valid_reg <= valid_d1_reg;
      if (valid_d1_reg) begin
        out_idx_reg <= idx_d1_reg;
        do_re_reg   <= rd_data[W-1 -: FLOAT_PRECISION];
        do_im_reg   <= rd_data[FLOAT_PRECISION-1:0];
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_idx   = out_idx_reg;
  assign bus.do_re     = do_re_reg;
  assign bus.do_im     = do_im_reg;
  assign bus.overflow  = overflow_reg;

endmodule
